pc_call_stack: RTL and testbench
================================

PC_CALL_STACK -- requirements
Module: pc_call_stack

Interface
REQ-001 Parameter N, default 64, datapath width of PC, in and stack entries (N >= 8).
REQ-002 Parameter DEPTH, default 8, number of return-stack entries (power of 2, >= 2).
REQ-003 Parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 clock  input  1  rising-edge clock; the block uses one clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in  input  N  branch offset (word count, signed) or absolute target, per PS.
REQ-007 PS  input  3  PC function select (see REQ-012).
REQ-008 stall  input  1  when high, PC, stack and count hold.
REQ-009 clear_err  input  1  synchronous clear of sticky error flags.
REQ-010 PC, PC4  output  N each  current PC; PC + 4 (combinational).
REQ-011 depth  output  clog2(DEPTH)+1  valid entries; full, empty  output  1 each; overflow, underflow  output  1 each, sticky.

Function
REQ-012 PS decode on the rising clock edge when stall = 0:
 - 000: PC <- PC.
 - 001: PC <- PC4.
 - 010: PC <- in.
 - 011: PC <- PC4 + (in << 2).
 - 100: call relative; push PC4; PC <- PC4 + (in << 2).
 - 101: return; PC <- top; pop.
 - 110: call register; push PC4; PC <- in.
 - 111: reserved; behaves as 000.
REQ-013 The shift is (in << 2) with in[N-1:N-2] discarded; all sums are modulo 2^N, with no carry out.
REQ-014 PC4 = PC + 4 modulo 2^N, combinational from the PC register.
REQ-015 Push and pop take effect on the same edge as the PC update; top reflects the new entry on the next cycle (zero-bubble return after call).
REQ-016 The stack is a circular buffer with a top pointer; depth counts 0..DEPTH; full = (depth == DEPTH); empty = (depth == 0).
REQ-017 Push when full: overwrite the oldest entry, top pointer advances, depth stays DEPTH, overflow set to 1.
REQ-018 Pop when empty: PC <- PC4, pointer and depth unchanged, underflow set to 1.
REQ-019 overflow and underflow stay set until reset or clear_err = 1 at a clock edge.
REQ-020 If clear_err coincides with a new error event, the flag ends set.
REQ-021 stall = 1 blocks all PC, pointer and depth updates, including push and pop.
REQ-022 clear_err is honoured even when stall = 1.
REQ-023 The block is single-ported: one stack operation per cycle, with no simultaneous push and pop.
REQ-024 Stack entry contents are not required to be reset.

Reset
REQ-025 reset = 1 immediately, without a clock edge, forces: PC = RESET_VECTOR, depth = 0, top pointer = 0, empty = 1, full = 0, overflow = 0, underflow = 0.
REQ-026 While reset = 1, all inputs are ignored.
REQ-027 After reset deasserts, the first update occurs at the next rising edge.
REQ-028 A reset asserted mid-sequence (e.g. between call and return) discards all stack state.

Verification
REQ-029 Reset, then PS = 001 for 3 cycles -> PC goes 0, 4, 8, 12; PC4 = 16.
REQ-030 PC = 0x100, PS = 100, in = 5 -> PC = 0x118, depth = 1; next cycle PS = 101 -> PC = 0x104, depth = 0, empty = 1.
REQ-031 DEPTH = 8, nine PS = 110 calls with in = 0x1000, starting at PC = 0x0:
 - After the ninth call: depth = 8, full = 1, overflow = 1.
 - Eight returns then yield the return addresses of calls 9 down to 2 (in = 0x1000 each, so all equal 0x1004) and end with empty = 1.
 - A ninth return gives PC = PC4 and underflow = 1.
REQ-032 PC = 0x200, stall = 1, PS = 100 for 2 cycles -> PC = 0x200 and depth = 0 throughout; stall = 0 -> call executes on the next edge.
REQ-033 N = 16, PC = 0xFFFC, PS = 001 -> PC = 0x0000.
REQ-034 PC = 0x40, PS = 011, in = all-ones (-1) -> PC = 0x40.
REQ-035 Async reset pulsed mid-cycle with depth = 3 and overflow = 1 -> outputs take reset values before the next edge.

Source files
------------

// File: rtl/pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module   : pc_call_stack
// Brief    : Program counter with PS-selected update and circular return stack.
// Revision : 1.0
// ============================================================================
module pc_call_stack #(
    parameter int            N            = 64,
    parameter int            DEPTH        = 8,
    parameter logic [N-1:0]  RESET_VECTOR = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [N-1:0]              in,
    input  logic [2:0]                PS,
    input  logic                      stall,
    input  logic                      clear_err,
    output logic [N-1:0]              PC,
    output logic [N-1:0]              PC4,
    output logic [$clog2(DEPTH):0]    depth,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] c_ps_hold     = 3'b000;
    localparam logic [2:0] c_ps_next     = 3'b001;
    localparam logic [2:0] c_ps_jump     = 3'b010;
    localparam logic [2:0] c_ps_branch   = 3'b011;
    localparam logic [2:0] c_ps_call_rel = 3'b100;
    localparam logic [2:0] c_ps_return   = 3'b101;
    localparam logic [2:0] c_ps_call_reg = 3'b110;

    localparam logic [CW-1:0] c_full_cnt = CW'(DEPTH);
    localparam logic [PW-1:0] c_ptr_one  = PW'(1);
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    logic [N-1:0]  pc_q, pc_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_en;
    logic [N-1:0]  pc4_w;
    logic [N-1:0]  rel_target_w;
    logic [N-1:0]  top_w;
    logic          full_w;

    logic [N-1:0]  stack_mem [DEPTH];

    assign pc4_w        = pc_q + N'(4);
    // The two MSBs of the offset fall off the shift; the sum wraps mod 2^N.
    assign rel_target_w = pc4_w + {in[N-3:0], 2'b00};
    // ptr_q is the next free slot, so the top entry sits one below it.
    assign top_w        = stack_mem[ptr_q - c_ptr_one];
    assign full_w       = (cnt_q == c_full_cnt);

    always_comb begin
        pc_d    = pc_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q & ~clear_err;
        unf_d   = unf_q & ~clear_err;
        push_en = 1'b0;
        if (!stall) begin
            case (PS)
                c_ps_hold:     pc_d = pc_q;
                c_ps_next:     pc_d = pc4_w;
                c_ps_jump:     pc_d = in;
                c_ps_branch:   pc_d = rel_target_w;
                c_ps_call_rel: begin
                    pc_d    = rel_target_w;
                    push_en = 1'b1;
                end
                c_ps_return: begin
                    if (cnt_q == '0) begin
                        pc_d  = pc4_w;
                        unf_d = 1'b1;
                    end else begin
                        pc_d  = top_w;
                        ptr_d = ptr_q - c_ptr_one;
                        cnt_d = cnt_q - c_cnt_one;
                    end
                end
                c_ps_call_reg: begin
                    pc_d    = in;
                    push_en = 1'b1;
                end
                default:       pc_d = pc_q;
            endcase
        end
        // A full push lands on the oldest slot because the buffer has wrapped.
        if (push_en) begin
            ptr_d = ptr_q + c_ptr_one;
            if (full_w) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_en && !reset) begin
            stack_mem[ptr_q] <= pc4_w;
        end
    end

    assign PC        = pc_q;
    assign PC4       = pc4_w;
    assign depth     = cnt_q;
    assign full      = full_w;
    assign empty     = (cnt_q == '0);
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_call_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_call_stack
// Brief    : Directed self-checking bench for pc_call_stack (N=64 and N=16).
// Revision : 1.0
// ============================================================================
module tb_pc_call_stack;

    logic        clock;
    logic        reset;
    logic [63:0] in;
    logic [2:0]  PS;
    logic        stall;
    logic        clear_err;
    logic [63:0] PC, PC4;
    logic [3:0]  depth;
    logic        full, empty, overflow, underflow;

    logic [15:0] in16;
    logic [2:0]  ps16;
    logic [15:0] pc16, pc4_16;
    logic [3:0]  depth16;
    logic        full16, empty16, ovf16, unf16;

    int n_checks = 0;
    int n_errors = 0;

    pc_call_stack #(.N(64), .DEPTH(8), .RESET_VECTOR(64'h0)) u_dut (
        .clock(clock), .reset(reset), .in(in), .PS(PS), .stall(stall),
        .clear_err(clear_err), .PC(PC), .PC4(PC4), .depth(depth), .full(full),
        .empty(empty), .overflow(overflow), .underflow(underflow)
    );

    pc_call_stack #(.N(16), .DEPTH(8), .RESET_VECTOR(16'h0)) u_dut16 (
        .clock(clock), .reset(reset), .in(in16), .PS(ps16), .stall(1'b0),
        .clear_err(1'b0), .PC(pc16), .PC4(pc4_16), .depth(depth16), .full(full16),
        .empty(empty16), .overflow(ovf16), .underflow(unf16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one operation, let the edge happen, settle just after it.
    task automatic step(input logic [2:0] ps, input logic [63:0] val);
        PS = ps;
        in = val;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; in = '0; PS = 3'b000; stall = 1'b0; clear_err = 1'b0;
        in16 = '0; ps16 = 3'b000;
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", PC, 64'h0);
        check("rst_depth", depth, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        reset = 1'b0;

        // Sequential fetch, with the 16-bit instance wrapping 0xFFFC -> 0
        in16 = 16'hFFFC; ps16 = 3'b010;
        step(3'b001, 0); check("seq_pc1", PC, 64'h4);
        check("n16_load", pc16, 16'hFFFC);
        ps16 = 3'b001;
        step(3'b001, 0); check("seq_pc2", PC, 64'h8);
        check("n16_wrap", pc16, 16'h0000);
        ps16 = 3'b000;
        step(3'b001, 0); check("seq_pc3", PC, 64'hC);
        check("seq_pc4", PC4, 64'h10);

        // Relative call then zero-bubble return
        step(3'b010, 64'h100); check("jump", PC, 64'h100);
        step(3'b100, 64'd5);
        check("callrel_pc", PC, 64'h118);
        check("callrel_depth", depth, 1);
        step(3'b101, 0);
        check("ret_pc", PC, 64'h104);
        check("ret_depth", depth, 0);
        check("ret_empty", empty, 1);

        // Nine register calls into an 8-deep stack
        step(3'b010, 64'h0);
        for (int i = 0; i < 8; i++) step(3'b110, 64'h1000);
        check("call8_full", full, 1);
        check("call8_ovf", overflow, 0);
        step(3'b110, 64'h1000);
        check("call9_depth", depth, 8);
        check("call9_full", full, 1);
        check("call9_ovf", overflow, 1);
        for (int i = 0; i < 8; i++) begin
            step(3'b101, 0);
            check("ret_chain_pc", PC, 64'h1004);
        end
        check("ret_chain_empty", empty, 1);
        step(3'b101, 0);
        check("underflow_pc", PC, 64'h1008);
        check("underflow_flag", underflow, 1);

        clear_err = 1'b1;
        step(3'b000, 0);
        check("clr_ovf", overflow, 0);
        check("clr_unf", underflow, 0);
        // clear coinciding with a new underflow leaves the flag set
        step(3'b101, 0);
        check("clr_vs_event_unf", underflow, 1);
        check("clr_vs_event_pc", PC, 64'h100C);
        step(3'b000, 0);
        clear_err = 1'b0;

        // LIFO ordering with distinct return addresses
        step(3'b010, 64'h0);
        step(3'b110, 64'h200);
        step(3'b110, 64'h300);
        check("lifo_depth", depth, 2);
        step(3'b101, 0); check("lifo_ret1", PC, 64'h204);
        step(3'b101, 0); check("lifo_ret2", PC, 64'h4);

        // Stall blocks a call; clear_err still acts during stall
        step(3'b010, 64'h1FC);
        step(3'b101, 0);
        check("pre_stall_pc", PC, 64'h200);
        check("pre_stall_unf", underflow, 1);
        stall = 1'b1; clear_err = 1'b1;
        step(3'b100, 0);
        check("stall1_pc", PC, 64'h200);
        check("stall1_depth", depth, 0);
        check("stall_clr_unf", underflow, 0);
        clear_err = 1'b0;
        step(3'b100, 0);
        check("stall2_pc", PC, 64'h200);
        check("stall2_depth", depth, 0);
        stall = 1'b0;
        step(3'b100, 0);
        check("unstall_pc", PC, 64'h204);
        check("unstall_depth", depth, 1);

        // Branch by -1 word lands back on the same PC
        step(3'b010, 64'h40);
        step(3'b011, '1);
        check("branch_neg1", PC, 64'h40);
        step(3'b111, 64'h1234);
        check("reserved_hold", PC, 64'h40);

        // Build depth 3 with overflow, then pulse reset mid-cycle
        for (int i = 0; i < 8; i++) step(3'b110, 64'h500);
        for (int i = 0; i < 5; i++) step(3'b101, 0);
        check("pre_rst_depth", depth, 3);
        check("pre_rst_ovf", overflow, 1);
        #2 reset = 1'b1;
        #1;
        check("async_pc", PC, 64'h0);
        check("async_depth", depth, 0);
        check("async_empty", empty, 1);
        check("async_ovf", overflow, 0);
        #1 reset = 1'b0;
        step(3'b001, 0);
        check("post_rst_pc", PC, 64'h4);
        step(3'b101, 0);
        check("post_rst_ret_pc", PC, 64'h8);
        check("post_rst_unf", underflow, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
